// File: rtl/sdram_mode_reg_sequencer_if.sv
// ---------------------------------------------------------------------------
// sdram_mode_reg_sequencer_if
//
// Bundle for the Load-Mode-Register sequencer. It groups the request
// handshake, the SDRAM command/address bus, and the shadowed MRS fields.
//
// Parameters
//   ADDR_W  SDRAM address bus width
//   BA_W    SDRAM bank address width
//
// Signals (direction seen from the sequencer, i.e. the slave modport)
//   sdram_init     in   power-up init complete; requests ignored while 0
//   mode_reg_en    in   request strobe, sampled only while idle
//   mode_reg_sel   in   0 = MRS (BA=0), 1 = EMRS (BA=1)
//   mode_reg_val   in   register value to load
//   mode_reg_busy  out  sequence in progress
//   mode_reg_done  out  one-cycle completion pulse
//   sdram_cmd      out  {cs_n, ras_n, cas_n, we_n}
//   sdram_ba       out  bank address
//   sdram_addr     out  address bus
//   cas_latency    out  shadow of MRS[6:4]
//   burst_len      out  shadow of MRS[2:0]
//
// Modports
//   slave   the sequencer itself
//   master  the requester / arbiter side
// ---------------------------------------------------------------------------
interface sdram_mode_reg_sequencer_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned BA_W   = 2
);

    logic              sdram_init;
    logic              mode_reg_en;
    logic              mode_reg_sel;
    logic [ADDR_W-1:0] mode_reg_val;
    logic              mode_reg_busy;
    logic              mode_reg_done;
    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [2:0]        cas_latency;
    logic [2:0]        burst_len;

    modport slave (
        input  sdram_init,
        input  mode_reg_en,
        input  mode_reg_sel,
        input  mode_reg_val,
        output mode_reg_busy,
        output mode_reg_done,
        output sdram_cmd,
        output sdram_ba,
        output sdram_addr,
        output cas_latency,
        output burst_len
    );

    modport master (
        output sdram_init,
        output mode_reg_en,
        output mode_reg_sel,
        output mode_reg_val,
        input  mode_reg_busy,
        input  mode_reg_done,
        input  sdram_cmd,
        input  sdram_ba,
        input  sdram_addr,
        input  cas_latency,
        input  burst_len
    );

endinterface

// File: rtl/sdram_mode_reg_sequencer.sv
// ---------------------------------------------------------------------------
// sdram_mode_reg_sequencer
//
// Load-Mode-Register sequencer for the SDRAM controller. Accepts a single
// request to program the Mode Register (MRS, BA=0) or the Extended Mode
// Register (EMRS, BA=1), optionally preceded by PRECHARGE ALL, enforces
// tRP / tMRD spacing and returns a one-cycle done pulse. The last MRS value
// written is shadowed (CAS latency, burst length code) for the read/write
// paths. The cmd/ba/addr outputs are muxed onto the SDRAM pins by the
// top-level arbiter.
//
// Build option
//   SDRAM_MRS_PRECHARGE_EN  defined: PRECHARGE ALL + tRP wait precede LMR.
//                           undefined: LMR is issued directly; the caller
//                           guarantees all banks are idle and T_RP is unused.
//
// Parameters
//   ADDR_W  address bus width (>=11, A10 is the precharge-all bit)
//   BA_W    bank address width (>=1)
//   T_RP    PRECHARGE -> next command spacing in clocks (>=1)
//   T_MRD   LMR -> done spacing in clocks (>=1)
//
// Ports
//   sys_clk  system clock, all logic on posedge
//   sys_rst  synchronous active-high reset; aborts any sequence at once
//   bus      sdram_mode_reg_sequencer_if.slave (request, SDRAM bus, shadows)
//
// Timing (E = edge that accepts the request; "at E+n" = value presented to
// the SDRAM at edge E+n):
//   with precharge:    PRE at E+1, LMR at E+1+T_RP, done at E+1+T_RP+T_MRD
//   without precharge: LMR at E+1, done at E+1+T_MRD
// ---------------------------------------------------------------------------
module sdram_mode_reg_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned BA_W   = 2,
    parameter int unsigned T_RP   = 2,
    parameter int unsigned T_MRD  = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    sdram_mode_reg_sequencer_if.slave  bus
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    localparam int unsigned T_MAX = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    // A wait state of N-1 cycles is entered with the counter at N-2 and
    // left when it reaches zero.
`ifdef SDRAM_MRS_PRECHARGE_EN
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
`endif
    localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_LMR,
        S_WAIT_MRD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] val_q,   val_d;
    logic              sel_q,   sel_d;
    logic [3:0]        cmd_q,   cmd_d;
    logic [BA_W-1:0]   ba_q,    ba_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [2:0]        cas_q,   cas_d;
    logic [2:0]        bl_q,    bl_d;

    // Next-state, counter, latch and shadow logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        sel_d   = sel_q;
        cas_d   = cas_q;
        bl_d    = bl_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mode_reg_en && bus.sdram_init) begin
                    val_d = bus.mode_reg_val;
                    sel_d = bus.mode_reg_sel;
`ifdef SDRAM_MRS_PRECHARGE_EN
                    state_d = S_PRE;
`else
                    state_d = S_LMR;
`endif
                end
            end
`ifdef SDRAM_MRS_PRECHARGE_EN
            S_PRE: begin
                if (T_RP > 1) begin
                    state_d = S_WAIT_RP;
                    cnt_d   = RP_LOAD;
                end else begin
                    state_d = S_LMR;
                end
            end
            S_WAIT_RP: begin
                if (cnt_q == '0) begin
                    state_d = S_LMR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            S_LMR: begin
                // Shadows follow MRS only; EMRS leaves them untouched.
                if (!sel_q) begin
                    cas_d = val_q[6:4];
                    bl_d  = val_q[2:0];
                end
                if (T_MRD > 1) begin
                    state_d = S_WAIT_MRD;
                    cnt_d   = MRD_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_MRD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered bus
    // shows each command during the cycle the state machine occupies it.
    always_comb begin
        cmd_d  = CMD_NOP;
        ba_d   = '0;
        addr_d = '0;
        busy_d = 1'b0;
        done_d = 1'b0;

        case (state_d)
            S_PRE: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
                busy_d     = 1'b1;
            end
            S_WAIT_RP, S_WAIT_MRD: begin
                busy_d = 1'b1;
            end
            S_LMR: begin
                cmd_d  = CMD_LMR;
                addr_d = val_d;
                ba_d   = BA_W'(sel_d);
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            sel_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cas_q   <= '0;
            bl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            sel_q   <= sel_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cas_q   <= cas_d;
            bl_q    <= bl_d;
        end
    end

    assign bus.sdram_cmd     = cmd_q;
    assign bus.sdram_ba      = ba_q;
    assign bus.sdram_addr    = addr_q;
    assign bus.mode_reg_busy = busy_q;
    assign bus.mode_reg_done = done_q;
    assign bus.cas_latency   = cas_q;
    assign bus.burst_len     = bl_q;

endmodule
